// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped 8N1 UART with TX/RX FSMs, status flags and irq.
// Optional internal loopback (CON[7]) is built when UART_LOOPBACK_EN is defined.
module uart_ctrl #(
  parameter int          CLKS_PER_BIT = 10417,
  parameter logic [31:0] BASE_ADDR    = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  // Bus decode
  logic sel_txd;
  logic sel_rxd;
  logic sel_con;
  logic tx_wr;
  logic con_wr;
  logic rxd_rd;
  logic con_rd;

  assign sel_txd = (addr == BASE_ADDR);
  assign sel_rxd = (addr == BASE_ADDR + 32'd4);
  assign sel_con = (addr == BASE_ADDR + 32'd8);
  assign tx_wr   = mem_write & sel_txd;
  assign con_wr  = mem_write & sel_con;
  assign rxd_rd  = mem_read & sel_rxd;
  assign con_rd  = mem_read & sel_con;

  // Control / status registers
  logic       tx_irq_en;
  logic       rx_irq_en;
  logic       tx_done;
  logic       rx_valid;
  logic       rx_overrun;
  logic       frame_err;
  logic       tx_busy;
  logic       lb_en;
  logic [7:0] txd_q;
  logic [7:0] rxd_q;

  // TX datapath
  tx_state_t     tx_state;
  tx_state_t     tx_state_n;
  logic [CW-1:0] tx_cnt;
  logic [CW-1:0] tx_cnt_n;
  logic [2:0]    tx_bit;
  logic [2:0]    tx_bit_n;
  logic [7:0]    tx_shift;
  logic [7:0]    tx_shift_n;
  logic          tx_line;
  logic          tx_line_n;
  logic          tx_go;
  logic          tx_fin;

  // RX datapath
  rx_state_t     rx_state;
  rx_state_t     rx_state_n;
  logic [CW-1:0] rx_cnt;
  logic [CW-1:0] rx_cnt_n;
  logic [2:0]    rx_bit;
  logic [2:0]    rx_bit_n;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_shift_n;
  logic          rx_in;
  logic          sync1;
  logic          sync2;
  logic          rx_done;
  logic          rx_ferr;

  assign tx_busy = (tx_state != TX_IDLE);

`ifdef UART_LOOPBACK_EN
  logic lb_q;
  logic unused_wdata;

  assign lb_en        = lb_q;
  assign rx_in        = lb_q ? tx_line : uart_rx;
  assign uart_tx      = lb_q ? 1'b1 : tx_line;
  assign unused_wdata = ^{wdata[31:8], wdata[6:2]};

  // Loopback enable register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lb_q <= 1'b0;
    end else if (con_wr) begin
      lb_q <= wdata[7];
    end
  end
`else
  logic unused_wdata;

  assign lb_en        = 1'b0;
  assign rx_in        = uart_rx;
  assign uart_tx      = tx_line;
  assign unused_wdata = ^{wdata[31:8], wdata[7:2]};
`endif

  // TX state and shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  // TX next-state: start bit, 8 data bits LSB first, stop bit
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    tx_go      = 1'b0;
    tx_fin     = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (tx_wr) begin
          tx_go      = 1'b1;
          tx_state_n = TX_START;
          tx_cnt_n   = '0;
          tx_shift_n = wdata[7:0];
          tx_line_n  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_line_n  = tx_shift[0];
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            tx_line_n  = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 1'b1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_line_n  = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = TX_IDLE;
          tx_cnt_n   = '0;
          tx_fin     = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        tx_line_n  = 1'b1;
      end
    endcase
  end

  // RX synchroniser and state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      sync1    <= rx_in;
      sync2    <= sync1;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // RX next-state: mid-bit sampling after start-bit qualification
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (!sync2) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = sync2 ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {sync2, rx_shift[7:1]};
          if (rx_bit == 3'd7) begin
            rx_state_n = RX_STOP;
          end else begin
            rx_bit_n = rx_bit + 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n = '0;
          if (sync2) begin
            rx_done    = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            rx_ferr    = 1'b1;
            rx_state_n = RX_WAIT;
          end
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_WAIT: begin
        if (sync2) begin
          rx_state_n = RX_IDLE;
        end
      end
      default: begin
        rx_state_n = RX_IDLE;
      end
    endcase
  end

  // Data registers: last accepted TX byte, last good RX byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txd_q <= '0;
      rxd_q <= '0;
    end else begin
      if (tx_go) begin
        txd_q <= wdata[7:0];
      end
      if (rx_done) begin
        rxd_q <= rx_shift;
      end
    end
  end

  // Flags: a set in the same cycle as a clearing read wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_irq_en  <= 1'b0;
      rx_irq_en  <= 1'b0;
      tx_done    <= 1'b0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (con_wr) begin
        tx_irq_en <= wdata[0];
        rx_irq_en <= wdata[1];
      end
      tx_done    <= tx_fin | (tx_done & ~con_rd);
      rx_valid   <= rx_done | (rx_valid & ~rxd_rd);
      rx_overrun <= (rx_done & rx_valid & ~rxd_rd)
                  | (rx_overrun & ~con_rd);
      frame_err  <= rx_ferr | (frame_err & ~con_rd);
    end
  end

  // Read mux, unmapped addresses read 0
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_txd: rdata = {24'b0, txd_q};
      sel_rxd: rdata = {24'b0, rxd_q};
      sel_con: rdata = {24'b0, lb_en, frame_err, rx_overrun,
                        tx_busy, rx_valid, tx_done,
                        rx_irq_en, tx_irq_en};
      default: rdata = '0;
    endcase
  end

  assign irq = (tx_irq_en & tx_done) | (rx_irq_en & rx_valid);

endmodule
